mul_share_arbiter: RTL and testbench

//   Shares one pipelined WIDTH-bit multiplier among N_REQ requesters, which are

---
 rtl/mul_share_arbiter.sv | 90 +++++++++
 tb/tb_mul_share_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one pipelined multiplier among N_REQ requesters
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);
  localparam int TW = $clog2(N_REQ);
  logic [TW-1:0]    ptr_q, ptr_d, gnt_idx;
  logic [TW-1:0]    cand [N_REQ];
  logic             gnt;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             vld_q [LATENCY];
  logic             vld_d [LATENCY];
  logic [TW-1:0]    tag_q [LATENCY];
  logic [TW-1:0]    tag_d [LATENCY];
  logic [WIDTH-1:0] dat_q [LATENCY];
  logic [WIDTH-1:0] dat_d [LATENCY];
  logic             busy_q, busy_d;
  // first valid requester at or after ptr wins; descending scan lets the nearest overwrite
  always_comb begin
    gnt = 1'b0;
    gnt_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand[i] = TW'((int'(ptr_q) + i) % N_REQ);
      if (req_valid[cand[i]]) begin
        gnt = !reset;
        gnt_idx = cand[i];
      end
    end
    req_ready = gnt ? N_REQ'(1'b1) << gnt_idx : '0;
    ptr_d = gnt ? (gnt_idx == TW'(N_REQ - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
  end
  // operand mux for the granted requester
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == TW'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end
  // pipeline advance; data and tags only move with a valid so rsp_data holds between pulses
  always_comb begin
    vld_d[0] = gnt;
    tag_d[0] = gnt ? gnt_idx : tag_q[0];
    dat_d[0] = gnt ? a_sel * b_sel : dat_q[0];
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      tag_d[k] = vld_q[k-1] ? tag_q[k-1] : tag_q[k];
      dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
    end
    busy_d = 1'b0;
    for (int k = 0; k < LATENCY; k++) busy_d = busy_d | vld_d[k];
  end
  // state registers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      busy_q <= 1'b0;
      for (int k = 0; k < LATENCY; k++) begin
        vld_q[k] <= 1'b0;
        tag_q[k] <= '0;
        dat_q[k] <= '0;
      end
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      for (int k = 0; k < LATENCY; k++) begin
        vld_q[k] <= vld_d[k];
        tag_q[k] <= tag_d[k];
        dat_q[k] <= dat_d[k];
      end
    end
  end
  assign rsp_valid = vld_q[LATENCY-1] ? N_REQ'(1'b1) << tag_q[LATENCY-1] : '0;
  assign rsp_data  = dat_q[LATENCY-1];
  assign busy      = busy_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: randomized and directed check of mul_share_arbiter against a queue model
module tb_mul_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 3;
  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;
  typedef struct {int tag; logic [W-1:0] d; int due;} ent_t;
  ent_t         q[$];
  bit   [N-1:0] pend;
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];
  logic [W-1:0] last;
  int           cyc, mptr, n_chk, n_fail;
  mul_share_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] f;
    f = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return f[W-1:0];
  endfunction
  function automatic int model_grant();
    for (int k = 0; k < N; k++) if (pend[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction
  task automatic load(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[i] = 1'b1;
    pa[i] = a;
    pb[i] = b;
  endtask
  task automatic tick(input bit r);
    int g;
    rst = r;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_a[i*W +: W] = pa[i];
      req_b[i*W +: W] = pb[i];
    end
    @(negedge clk);
    g = r ? -1 : model_grant();
    check("req_ready", req_ready, g < 0 ? 64'd0 : 64'd1 << g);
    check("busy", busy, q.size() != 0);
    if (q.size() != 0 && q[0].due == cyc) begin
      check("rsp_valid", rsp_valid, 64'd1 << q[0].tag);
      check("rsp_data", rsp_data, q[0].d);
      last = q[0].d;
      void'(q.pop_front());
    end else begin
      check("rsp_valid_idle", rsp_valid, 0);
      check("rsp_data_hold", rsp_data, last);
    end
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      mptr = 0;
      last = '0;
    end else if (g >= 0) begin
      q.push_back('{g, prod(pa[g], pb[g]), cyc + L - 1});
      mptr = (g + 1) % N;
      pend[g] = 1'b0;
    end
    #1;
  endtask
  task automatic drain(input int n);
    pend = '0;
    repeat (n) tick(1'b0);
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    pend = '0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    mptr = 0;
    last = '0;
    load(1, 2, 3);
    tick(1'b0);
    drain(L + 1);
    check("single_op_data", rsp_data, 6);
    tick(1'b1);
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) load(i, $urandom(), $urandom_range(1000, 0));
      tick(1'b0);
    end
    drain(L + 1);
    for (int c = 0; c < 8; c++) begin
      if (!pend[0]) load(0, $urandom(), $urandom());
      if (!pend[2]) load(2, $urandom(), $urandom());
      tick(1'b0);
    end
    drain(L + 1);
    load(0, 32'hFFFF_FFFF, 2);
    tick(1'b0);
    drain(L + 1);
    check("wrap_data", rsp_data, 32'hFFFF_FFFE);
    load(0, 32'h8000_0000, 2);
    tick(1'b0);
    drain(L + 1);
    check("trunc_data", rsp_data, 0);
    for (int i = 0; i < 3; i++) load(i, i + 5, i + 7);
    repeat (3) tick(1'b0);
    pend = '0;
    tick(1'b1);
    drain(L + 2);
    check("busy_after_reset", busy, 0);
    for (int i = 0; i < N; i++) load(i, i + 1, 9);
    tick(1'b0);
    drain(L + 1);
    for (int k = 1; k <= 5; k++) begin
      load(3, k, k + 1);
      tick(1'b0);
    end
    drain(L + 1);
    check("b2b_last_data", rsp_data, 30);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1)
          load(i, $urandom_range(3, 0) == 0 ? W'($urandom_range(15, 0)) : W'($urandom()),
               $urandom_range(3, 0) == 0 ? W'($urandom_range(15, 0)) : W'($urandom()));
        else if (pend[i] && $urandom_range(15, 0) == 0)
          pend[i] = 1'b0;
      end
      tick($urandom_range(63, 0) == 0);
    end
    drain(L + 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
